// File: rtl/rej_uniform_sampler.sv
// Rejection sampler: scans SHAKE128 rate blocks as 12-bit candidates, keeps those < q=3329.
// Latency: candidate k of a block is evaluated k cycles after the latch edge; its output is registered one edge later.
// Backpressure: none on the output side; upstream is throttled by the level request squeeze_req.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   start             pulse to begin a new polynomial (honoured only when idle)
//   state_in[1599:0]  permutation state; only the 1344-bit rate [1343:0] is used
//   state_valid       fresh block present on state_in (honoured only while waiting)
//   squeeze_req       level request for the next squeezed block
//   coeff, coeff_idx, coeff_valid   accepted coefficient and its position 0..255
//   done              pulse alongside coefficient 255
//   busy              high whenever not idle
module rej_uniform_sampler (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1599:0] state_in,
    input  logic          state_valid,
    output logic          squeeze_req,
    output logic [11:0]   coeff,
    output logic [7:0]    coeff_idx,
    output logic          coeff_valid,
    output logic          done,
    output logic          busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_SCAN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [11:0] Q        = 12'd3329;
    localparam logic [6:0]  LAST_K   = 7'd111;
    localparam logic [8:0]  LAST_IDX = 9'd255;

    logic [1:0]    state;
    logic [8:0]    cnt;
    logic [6:0]    k;
    logic [1343:0] blk;

    logic [11:0] cand;
    logic        accept;

    // Capacity bits of the permutation state play no part in sampling.
    logic unused_capacity;
    assign unused_capacity = ^state_in[1599:1344];

    // The block buffer shifts right by one candidate per scan cycle, so the
    // candidate under test always sits in the low 12 bits. This is the
    // little-endian byte-triplet split: bits [12k+11:12k] of the original block.
    assign cand   = blk[11:0];
    assign accept = (cand < Q);

    assign squeeze_req = (state == S_WAIT);
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= 9'd0;
            k           <= 7'd0;
            blk         <= '0;
            coeff       <= 12'd0;
            coeff_idx   <= 8'd0;
            coeff_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            coeff_valid <= 1'b0;
            done        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt   <= 9'd0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (state_valid) begin
                        blk   <= state_in[1343:0];
                        k     <= 7'd0;
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    blk <= {12'd0, blk[1343:12]};
                    if (accept) begin
                        coeff       <= cand;
                        coeff_idx   <= cnt[7:0];
                        coeff_valid <= 1'b1;
                        cnt         <= cnt + 9'd1;
                    end
                    // Completing the polynomial wins over the end-of-block
                    // re-request; leftover candidates are simply dropped.
                    if (accept && (cnt == LAST_IDX)) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (k == LAST_K) begin
                        state <= S_WAIT;
                    end else begin
                        k <= k + 7'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rej_uniform_sampler.sv
module tb_rej_uniform_sampler;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1599:0] state_in;
    logic          state_valid;
    logic          squeeze_req;
    logic [11:0]   coeff;
    logic [7:0]    coeff_idx;
    logic          coeff_valid;
    logic          done;
    logic          busy;

    rej_uniform_sampler dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .state_in    (state_in),
        .state_valid (state_valid),
        .squeeze_req (squeeze_req),
        .coeff       (coeff),
        .coeff_idx   (coeff_idx),
        .coeff_valid (coeff_valid),
        .done        (done),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rb [168];     // rate bytes of the next block to deliver
    int         exp_cnt;      // coefficients the reference model has accepted so far
    int         blk_status;   // 0 = more blocks needed, 1 = polynomial complete, 2 = aborted
    bit         rst_test;     // pull reset right after coefficient 40 is seen

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic rand_state();
        for (int i = 0; i < 50; i++) state_in[32*i +: 32] = $urandom();
    endtask

    task automatic fill_random();
        for (int i = 0; i < 168; i++) rb[i] = 8'($urandom_range(0, 255));
    endtask

    // Build bytes from a two-candidate pattern (inverse of the byte-triplet split).
    task automatic fill_pair(input int d1, input int d2);
        for (int t = 0; t < 56; t++) begin
            rb[3*t]   = 8'(d1 & 255);
            rb[3*t+1] = 8'(((d1 >> 8) & 15) | ((d2 & 15) << 4));
            rb[3*t+2] = 8'((d2 >> 4) & 255);
        end
    endtask

    task automatic start_poly();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("sqreq_after_start", 32'(squeeze_req), 32'd1);
        exp_cnt    = 0;
        blk_status = 0;
    endtask

    task automatic run_block(input bit inj);
        int cand [112];
        int w;
        bit expv;
        blk_status = 0;
        w = 0;
        while (!squeeze_req && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("sqreq_wait", 32'(squeeze_req), 32'd1);
        if (!squeeze_req) begin
            blk_status = 2;
            return;
        end
        // Reference: little-endian byte triplets -> two 12-bit candidates each.
        for (int t = 0; t < 56; t++) begin
            cand[2*t]   = int'(rb[3*t]) | ((int'(rb[3*t+1]) & 15) << 8);
            cand[2*t+1] = (int'(rb[3*t+1]) >> 4) | (int'(rb[3*t+2]) << 4);
        end
        rand_state();
        for (int i = 0; i < 168; i++) state_in[8*i +: 8] = rb[i];
        state_valid = 1'b1;
        @(posedge clk);
        #1 state_valid = 1'b0;
        rand_state();   // buffer must already hold its own copy
        @(negedge clk);
        chk("sqreq_low_in_scan", 32'(squeeze_req), 32'd0);
        for (int c = 0; c < 112; c++) begin
            @(negedge clk);
            expv = (cand[c] < 3329);
            chk("coeff_valid", 32'(coeff_valid), 32'(expv));
            chk("done", 32'(done), 32'(expv && exp_cnt == 255));
            if (expv) begin
                chk("coeff", 32'(coeff), 32'(cand[c]));
                chk("coeff_idx", 32'(coeff_idx), 32'(exp_cnt));
                exp_cnt++;
            end
            if (rst_test && expv && exp_cnt == 41) begin
                state_valid = 1'b0;
                start = 1'b0;
                #2 rst = 1'b0;
                #1;
                chk("rst_coeff_valid", 32'(coeff_valid), 32'd0);
                chk("rst_coeff", 32'(coeff), 32'd0);
                chk("rst_coeff_idx", 32'(coeff_idx), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_sqreq", 32'(squeeze_req), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                blk_status = 2;
                return;
            end
            if (exp_cnt == 256) begin
                state_valid = 1'b0;
                start = 1'b0;
                chk("busy_on_done", 32'(busy), 32'd1);
                @(negedge clk);
                chk("busy_after_done", 32'(busy), 32'd0);
                chk("sqreq_after_done", 32'(squeeze_req), 32'd0);
                chk("valid_after_done", 32'(coeff_valid), 32'd0);
                blk_status = 1;
                return;
            end
            state_valid = inj && (c == 20);
            start       = inj && (c == 30);
            if (inj && c == 20) rand_state();
        end
        state_valid = 1'b0;
        start = 1'b0;
        chk("sqreq_rerequest", 32'(squeeze_req), 32'd1);
    endtask

    task automatic finish_poly(input bit rnd, input bit inj);
        int n = 0;
        while (blk_status == 0 && n < 12) begin
            if (rnd) fill_random();
            run_block(inj);
            n++;
        end
        chk("poly_complete", 32'(blk_status), 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        state_valid = 1'b0;
        state_in = '0;
        rst_test = 1'b0;
        exp_cnt = 0;
        blk_status = 0;
        repeat (3) @(negedge clk);
        chk("reset_sqreq", 32'(squeeze_req), 32'd0);
        chk("reset_coeff", 32'(coeff), 32'd0);
        chk("reset_coeff_idx", 32'(coeff_idx), 32'd0);
        chk("reset_coeff_valid", 32'(coeff_valid), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // Byte pattern 01 23 45: 112 + 112 + 32 coefficients.
        for (int t = 0; t < 56; t++) begin
            rb[3*t] = 8'h01; rb[3*t+1] = 8'h23; rb[3*t+2] = 8'h45;
        end
        start_poly();
        finish_poly(1'b0, 1'b0);
        chk("pattern_total", 32'(exp_cnt), 32'd256);

        // All rejected, then an all-zero block proves cnt stayed at 0
        // and checks first-output latency and continuous acceptance.
        start_poly();
        for (int i = 0; i < 168; i++) rb[i] = 8'hFF;
        run_block(1'b0);
        for (int i = 0; i < 168; i++) rb[i] = 8'h00;
        run_block(1'b0);
        finish_poly(1'b1, 1'b0);

        // Compare boundary 3328 / 3329, with ignored state_valid and start mid-scan.
        start_poly();
        fill_pair(3328, 3329);
        finish_poly(1'b0, 1'b1);

        // Random block, reset asynchronously right after coefficient 40.
        start_poly();
        rst_test = 1'b1;
        for (int n = 0; n < 6 && blk_status == 0; n++) begin
            fill_random();
            run_block(1'b1);
        end
        rst_test = 1'b0;
        chk("reset_abort", 32'(blk_status), 32'd2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_busy", 32'(busy), 32'd0);

        // Fresh polynomial after reset must restart at index 0.
        start_poly();
        finish_poly(1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
